// File: rtl/vq_encoder_if.sv
// RAM-side bus of the VQ encoder: codebook (W), tag and picture RAM ports.
// The encoder uses the master modport; the RAM models use the slave modport.
interface vq_encoder_if;
    logic [23:0] RAM_W_Q;
    logic [23:0] RAM_W_D;
    logic [19:0] RAM_W_A;
    logic        RAM_W_WE;
    logic        RAM_W_OE;
    logic [23:0] RAM_TAG_Q;
    logic [23:0] RAM_TAG_D;
    logic [19:0] RAM_TAG_A;
    logic        RAM_TAG_WE;
    logic        RAM_TAG_OE;
    logic [23:0] RAM_PIC_Q;
    logic [23:0] RAM_PIC_D;
    logic [19:0] RAM_PIC_A;
    logic        RAM_PIC_WE;
    logic        RAM_PIC_OE;

    modport master (
        input  RAM_W_Q,   output RAM_W_D,   output RAM_W_A,   output RAM_W_WE,   output RAM_W_OE,
        input  RAM_TAG_Q, output RAM_TAG_D, output RAM_TAG_A, output RAM_TAG_WE, output RAM_TAG_OE,
        input  RAM_PIC_Q, output RAM_PIC_D, output RAM_PIC_A, output RAM_PIC_WE, output RAM_PIC_OE
    );

    modport slave (
        output RAM_W_Q,   input  RAM_W_D,   input  RAM_W_A,   input  RAM_W_WE,   input  RAM_W_OE,
        output RAM_TAG_Q, input  RAM_TAG_D, input  RAM_TAG_A, input  RAM_TAG_WE, input  RAM_TAG_OE,
        output RAM_PIC_Q, input  RAM_PIC_D, input  RAM_PIC_A, input  RAM_PIC_WE, input  RAM_PIC_OE
    );
endinterface

// File: rtl/vq_encoder.sv
// Vector-quantisation encoder: for every picture pixel, finds the nearest codebook
// entry (squared RGB distance, lowest index on ties) and writes its index to tag RAM.
module vq_encoder #(
    parameter int N_PIX = 4096,
    parameter int N_CB  = 16,
    parameter int IDX_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    vq_encoder_if.master ram,
    output logic         done
);
    localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    typedef enum logic [2:0] {INIT, RD_PIX, LD_PIX, RD_CB, CMP_CB, WR_TAG, FINISH} state_t;

    // Squared difference of two 8-bit channels via the 9-bit signed difference.
    function automatic logic [15:0] sq_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        logic [7:0]        m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[8] ? 8'(-d) : d[7:0];
        return {8'd0, m} * {8'd0, m};
    endfunction

    state_t             state_r, state_next_s;
    logic [PIX_W-1:0]   pix_idx_r, pix_idx_next_s;
    logic [IDX_W-1:0]   cb_idx_r, cb_idx_next_s;
    logic [IDX_W-1:0]   best_idx_r, best_idx_next_s;
    logic [17:0]        best_dist_r, best_dist_next_s;
    logic [23:0]        pix_reg_r, pix_reg_next_s;
    logic [17:0]        dist_s;
    logic [19:0]        pic_a_r, w_a_r, tag_a_r;
    logic [23:0]        tag_d_r;
    logic               pic_oe_r, w_oe_r, tag_we_r, done_r;
    logic               tag_q_unused;

    // Distance between the codebook word on the bus and the latched pixel.
    always_comb begin
        dist_s = 18'(sq_diff(ram.RAM_W_Q[23:16], pix_reg_r[23:16]))
               + 18'(sq_diff(ram.RAM_W_Q[15:8],  pix_reg_r[15:8]))
               + 18'(sq_diff(ram.RAM_W_Q[7:0],   pix_reg_r[7:0]));
    end

    // Next-state and datapath update.
    always_comb begin
        state_next_s     = state_r;
        pix_idx_next_s   = pix_idx_r;
        cb_idx_next_s    = cb_idx_r;
        best_idx_next_s  = best_idx_r;
        best_dist_next_s = best_dist_r;
        pix_reg_next_s   = pix_reg_r;
        case (state_r)
            INIT:   state_next_s = RD_PIX;
            RD_PIX: state_next_s = LD_PIX;
            LD_PIX: begin
                pix_reg_next_s = ram.RAM_PIC_Q;
                cb_idx_next_s  = {IDX_W{1'b0}};
                state_next_s   = RD_CB;
            end
            RD_CB:  state_next_s = CMP_CB;
            CMP_CB: begin
                // Strict less-than keeps the lowest index among equal distances.
                if ((cb_idx_r == {IDX_W{1'b0}}) || (dist_s < best_dist_r)) begin
                    best_dist_next_s = dist_s;
                    best_idx_next_s  = cb_idx_r;
                end else begin
                    best_dist_next_s = best_dist_r;
                    best_idx_next_s  = best_idx_r;
                end
                if (cb_idx_r == IDX_W'(N_CB - 1)) begin
                    state_next_s = WR_TAG;
                end else begin
                    cb_idx_next_s = cb_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_next_s  = RD_CB;
                end
            end
            WR_TAG: begin
                if (pix_idx_r == PIX_W'(N_PIX - 1)) begin
                    state_next_s = FINISH;
                end else begin
                    pix_idx_next_s = pix_idx_r + {{(PIX_W-1){1'b0}}, 1'b1};
                    state_next_s   = RD_PIX;
                end
            end
            FINISH: state_next_s = FINISH;
            default: state_next_s = INIT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= INIT;
            pix_idx_r   <= {PIX_W{1'b0}};
            cb_idx_r    <= {IDX_W{1'b0}};
            best_idx_r  <= {IDX_W{1'b0}};
            best_dist_r <= 18'd0;
            pix_reg_r   <= 24'd0;
        end else begin
            state_r     <= state_next_s;
            pix_idx_r   <= pix_idx_next_s;
            cb_idx_r    <= cb_idx_next_s;
            best_idx_r  <= best_idx_next_s;
            best_dist_r <= best_dist_next_s;
            pix_reg_r   <= pix_reg_next_s;
        end
    end

    // RAM controls are decoded from the next state so they are valid throughout each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pic_a_r  <= 20'd0;
            pic_oe_r <= 1'b0;
            w_a_r    <= 20'd0;
            w_oe_r   <= 1'b0;
            tag_a_r  <= 20'd0;
            tag_d_r  <= 24'd0;
            tag_we_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            pic_a_r  <= 20'(pix_idx_next_s);
            pic_oe_r <= (state_next_s == RD_PIX);
            w_a_r    <= 20'(cb_idx_next_s);
            w_oe_r   <= (state_next_s == RD_CB);
            tag_a_r  <= 20'(pix_idx_next_s);
            tag_d_r  <= 24'(best_idx_next_s);
            tag_we_r <= (state_next_s == WR_TAG);
            done_r   <= (state_next_s == FINISH);
        end
    end

    assign tag_q_unused   = ^ram.RAM_TAG_Q;

    assign ram.RAM_W_D    = 24'd0;
    assign ram.RAM_W_A    = w_a_r;
    assign ram.RAM_W_WE   = 1'b0;
    assign ram.RAM_W_OE   = w_oe_r;
    assign ram.RAM_TAG_D  = tag_d_r;
    assign ram.RAM_TAG_A  = tag_a_r;
    assign ram.RAM_TAG_WE = tag_we_r;
    assign ram.RAM_TAG_OE = 1'b0;
    assign ram.RAM_PIC_D  = 24'd0;
    assign ram.RAM_PIC_A  = pic_a_r;
    assign ram.RAM_PIC_WE = 1'b0;
    assign ram.RAM_PIC_OE = pic_oe_r;
    assign done           = done_r;
endmodule

// File: tb/tb_vq_encoder.sv
// Bench for vq_encoder: RAM models, tag-write scoreboard, and directed codebook/picture
// vectors with hand-computed nearest indices (exact match, ties, max distance, mid-run reset).
module tb_vq_encoder;
    localparam int N_PIX   = 8;
    localparam int N_CB    = 16;
    localparam int RUN_CYC = N_PIX * (3 + 2 * N_CB) + 1;

    typedef struct {
        logic [19:0] a;
        logic [23:0] d;
    } tag_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done;
    always #5 clk = ~clk;

    vq_encoder_if bus();
    vq_encoder #(.N_PIX(N_PIX), .N_CB(N_CB), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .ram(bus), .done(done)
    );

    logic [23:0] cb_mem  [N_CB];
    logic [23:0] pic_mem [N_PIX];
    logic [23:0] tag_mem [N_PIX];
    int          exp_idx [N_PIX];
    logic [23:0] pic_q = 24'd0;
    logic [23:0] w_q   = 24'd0;
    logic        fill_tags = 1'b0;
    logic        prev_we   = 1'b0;
    tag_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          viol       = 0;

    assign bus.RAM_PIC_Q = pic_q;
    assign bus.RAM_W_Q   = w_q;
    assign bus.RAM_TAG_Q = 24'h5A5A5A;

    // Synchronous RAMs: read data appears the cycle after an OE sample.
    always @(posedge clk) begin
        if (bus.RAM_PIC_OE) pic_q <= pic_mem[bus.RAM_PIC_A[2:0]];
        if (bus.RAM_W_OE)   w_q   <= cb_mem[bus.RAM_W_A[3:0]];
        if (fill_tags) begin
            for (int i = 0; i < N_PIX; i++) tag_mem[i] <= 24'hABCDEF;
        end else if (bus.RAM_TAG_WE) begin
            tag_mem[bus.RAM_TAG_A[2:0]] <= bus.RAM_TAG_D;
        end
    end

    // Monitor: protocol rules each cycle, and tag writes against the scoreboard.
    always @(negedge clk) begin
        tag_t e;
        if (rst) begin
            prev_we <= 1'b0;
        end else begin
            if (($countones({bus.RAM_PIC_OE, bus.RAM_W_OE, bus.RAM_TAG_WE}) > 1)
                || bus.RAM_PIC_WE || bus.RAM_W_WE || bus.RAM_TAG_OE
                || (bus.RAM_PIC_D != 24'd0) || (bus.RAM_W_D != 24'd0)
                || (bus.RAM_TAG_WE && prev_we)
                || (done && (bus.RAM_PIC_OE || bus.RAM_W_OE || bus.RAM_TAG_WE))
                || (bus.RAM_PIC_OE && (bus.RAM_PIC_A >= 20'(N_PIX)))
                || (bus.RAM_W_OE && (bus.RAM_W_A >= 20'(N_CB)))
                || (bus.RAM_TAG_WE && (bus.RAM_TAG_A >= 20'(N_PIX)))) begin
                viol = viol + 1;
            end
            prev_we <= bus.RAM_TAG_WE;
            if (bus.RAM_TAG_WE) begin
                compared = compared + 1;
                if (sb.size() == 0) begin
                    mismatched = mismatched + 1;
                    $display("FAIL tag_write: unexpected write addr=%0d data=%h", bus.RAM_TAG_A, bus.RAM_TAG_D);
                end else begin
                    e = sb.pop_front();
                    if ((bus.RAM_TAG_A != e.a) || (bus.RAM_TAG_D != e.d)) begin
                        mismatched = mismatched + 1;
                        $display("FAIL tag_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 bus.RAM_TAG_A, bus.RAM_TAG_D, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        compared = compared + 1;
        if (act !== expv) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctl"}, {bus.RAM_PIC_OE, bus.RAM_W_OE, bus.RAM_TAG_WE, done,
                             bus.RAM_PIC_A, bus.RAM_W_A, bus.RAM_TAG_A}, 128'd0);
        check({nm, "_data"}, {bus.RAM_TAG_D, bus.RAM_PIC_D, bus.RAM_W_D}, 128'd0);
    endtask

    task automatic setup(input int r);
        case (r)
            1: begin
                for (int i = 0; i < N_CB; i++) cb_mem[i] = 24'hFFFFFF;
                cb_mem[5] = 24'h123456;
                pic_mem = '{24'h123456, 24'hFFFFFF, 24'h000000, 24'h123457,
                            24'hF0F0F0, 24'h123456, 24'hFFFFFE, 24'h101010};
                exp_idx = '{5, 0, 5, 5, 0, 5, 0, 5};
            end
            2: begin
                for (int i = 0; i < N_CB; i++) cb_mem[i] = 24'hF0F0F0;
                cb_mem[2] = 24'h101010;
                cb_mem[9] = 24'h101010;
                pic_mem = '{24'h101010, 24'hF0F0F0, 24'h000000, 24'hFFFFFF,
                            24'h808080, 24'h7F7F7F, 24'h818181, 24'h101011};
                exp_idx = '{2, 0, 2, 0, 0, 2, 0, 2};
            end
            default: begin
                for (int i = 0; i < N_CB; i++) cb_mem[i] = 24'hFFFFFF;
                cb_mem[1] = 24'hFEFFFF;
                pic_mem = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h010000,
                            24'h7F0000, 24'hFE0000, 24'h808080, 24'h000000};
                exp_idx = '{1, 0, 0, 1, 1, 1, 1, 1};
            end
        endcase
    endtask

    task automatic push_expect();
        tag_t e;
        for (int i = 0; i < N_PIX; i++) begin
            e.a = 20'(i);
            e.d = 24'(exp_idx[i]);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        #1;
        check_zero(nm);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_and_check(input string nm);
        int cyc;
        cyc = 0;
        while ((done !== 1'b1) && (cyc < 2 * RUN_CYC)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, "_done_cycle"}, 128'(cyc), 128'(RUN_CYC));
        repeat (10) @(posedge clk);
        #1;
        check({nm, "_done_sticky"}, 128'(done), 128'd1);
        check({nm, "_sb_empty"}, 128'(sb.size()), 128'd0);
        check({nm, "_protocol"}, 128'(viol), 128'd0);
        for (int i = 0; i < N_PIX; i++) begin
            check($sformatf("%s_tag%0d", nm, i), 128'(tag_mem[i]), 128'(exp_idx[i]));
            check($sformatf("%s_roundtrip%0d", nm, i), 128'(cb_mem[tag_mem[i][3:0]]),
                  128'(cb_mem[exp_idx[i]]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        setup(1); do_reset("exact_rst"); push_expect(); run_and_check("exact");
        setup(2); do_reset("tie_rst");   push_expect(); run_and_check("tie");
        setup(3); do_reset("max_rst");   push_expect(); run_and_check("maxdist");

        // Mid-run reset: stale tags prefilled, reset lands in pixel 5's first compare.
        setup(1);
        fill_tags = 1'b1;
        @(posedge clk);
        #1 fill_tags = 1'b0;
        do_reset("pre_mid_rst");
        push_expect();
        repeat (1 + 35 * 5 + 3) @(posedge clk);
        #3;
        check("mid_pending", 128'(sb.size()), 128'd3);
        sb.delete();
        do_reset("mid_rst");
        check("mid_kept_tag0", 128'(tag_mem[0]), 128'd5);
        check("mid_stale_tag5", 128'(tag_mem[5]), 128'hABCDEF);
        push_expect();
        run_and_check("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
